// File: rtl/liushui_m_pkg.sv
// Shared definitions for the liushui_m memory stage: opcodes, reset PC and
// pipeline-latch field widths.
package liushui_m_pkg;

   localparam int W_DATA = 32;
   localparam int W_REG  = 5;
   localparam int W_TIME = 32;

   localparam logic [W_DATA-1:0] PC_RESET_DFLT = 32'h0000_3000;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;

endpackage

// File: rtl/liushui_m_if.sv
// E->M inputs, W-stage forwarding inputs and M->W latch outputs of the
// memory stage, bundled as one interface.
interface liushui_m_if;
   import liushui_m_pkg::*;

   logic [W_DATA-1:0] pc, code, in1, in2;
   logic [W_REG-1:0]  rgwriaddr;
   logic [W_TIME-1:0] rgwritime;
   logic [W_REG-1:0]  W_rgwriaddr;
   logic [W_TIME-1:0] W_rgwritime;
   logic [W_DATA-1:0] W_rgwridata;
   logic [W_DATA-1:0] npc, ncode, out1, out2;
   logic [W_REG-1:0]  nrgwriaddr;
   logic [W_TIME-1:0] nrgwritime;
   logic [W_DATA-1:0] M_rgwridata;

   modport master (
      output pc, code, in1, in2, rgwriaddr, rgwritime,
             W_rgwriaddr, W_rgwritime, W_rgwridata,
      input  npc, ncode, out1, out2, nrgwriaddr, nrgwritime, M_rgwridata
   );

   modport slave (
      input  pc, code, in1, in2, rgwriaddr, rgwritime,
             W_rgwriaddr, W_rgwritime, W_rgwridata,
      output npc, ncode, out1, out2, nrgwriaddr, nrgwritime, M_rgwridata
   );

endinterface

// File: rtl/liushui_m_dm.sv
// DEPTH-word data memory: async active-low clear of every word, byte-enable
// write at the rising edge, combinational read.
module liushui_dm #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] wr_word_d;

   assign rdata = mem_q[addr];

   // Merge enabled byte lanes into the current word so sub-word stores keep the rest.
   always_comb begin
      wr_word_d = mem_q[addr];
      for (int b = 0; b < 4; b++) begin
         if (be[b]) wr_word_d[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[addr] <= wr_word_d;
      end
   end

endmodule

// File: rtl/liushui_m.sv
// MIPS memory stage: store-data forwarding from W, data memory access and the
// M->W pipeline latch. Define LIUSHUI_M_SUBWORD_EN for lb/lbu/lh/lhu/sb/sh.
module liushui_m
   import liushui_m_pkg::*;
#(
   parameter int                DEPTH    = 1024,
   parameter logic [W_DATA-1:0] PC_RESET = PC_RESET_DFLT
) (
   input  logic     clk,
   input  logic     reset,
   liushui_m_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic [5:0]        op;
   logic [4:0]        rt;
   logic [AW-1:0]     idx;
   logic [W_DATA-1:0] st_data;
   logic              dm_we;
   logic [3:0]        dm_be;
   logic [31:0]       dm_wdata;
   logic [31:0]       dm_rdata;

   logic [W_DATA-1:0] npc_d, npc_q, ncode_d, ncode_q;
   logic [W_DATA-1:0] out1_d, out1_q, out2_d, out2_q;
   logic [W_REG-1:0]  nrgwriaddr_d, nrgwriaddr_q;
   logic [W_TIME-1:0] nrgwritime_d, nrgwritime_q;

`ifdef LIUSHUI_M_SUBWORD_EN
   logic [31:0] rd_byte_sh, rd_half_sh;
   assign rd_byte_sh = dm_rdata >> {bus.in1[1:0], 3'b000};
   assign rd_half_sh = dm_rdata >> {bus.in1[1], 4'b0000};
`endif

   assign op  = bus.code[31:26];
   assign rt  = bus.code[20:16];
   assign idx = bus.in1[AW+1:2];

   // Take the W result only when it is ready and targets our rt ($0 never forwards).
   assign st_data = (bus.W_rgwritime == '0 && bus.W_rgwriaddr == rt && rt != 5'd0)
                  ? bus.W_rgwridata : bus.in2;

   assign bus.M_rgwridata = (op == OP_JAL) ? bus.pc + 32'd8 : bus.in1;

   always_comb begin
      dm_we    = 1'b0;
      dm_be    = 4'b0000;
      dm_wdata = st_data;
      out2_d   = '0;
      case (op)
         OP_SW: begin
            dm_we = 1'b1;
            dm_be = 4'b1111;
         end
         OP_LW: out2_d = dm_rdata;
`ifdef LIUSHUI_M_SUBWORD_EN
         OP_SB: begin
            dm_we    = 1'b1;
            dm_be    = 4'b0001 << bus.in1[1:0];
            dm_wdata = {4{st_data[7:0]}};
         end
         OP_SH: begin
            dm_we    = 1'b1;
            dm_be    = bus.in1[1] ? 4'b1100 : 4'b0011;
            dm_wdata = {2{st_data[15:0]}};
         end
         OP_LB:  out2_d = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
         OP_LBU: out2_d = {24'd0, rd_byte_sh[7:0]};
         OP_LH:  out2_d = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
         OP_LHU: out2_d = {16'd0, rd_half_sh[15:0]};
`endif
         default: ;
      endcase
   end

   always_comb begin
      npc_d        = bus.pc;
      ncode_d      = bus.code;
      out1_d       = bus.M_rgwridata;
      nrgwriaddr_d = bus.rgwriaddr;
      nrgwritime_d = (bus.rgwritime == '0) ? '0 : bus.rgwritime - 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         npc_q        <= PC_RESET;
         ncode_q      <= '0;
         out1_q       <= '0;
         out2_q       <= '0;
         nrgwriaddr_q <= '0;
         nrgwritime_q <= '0;
      end else begin
         npc_q        <= npc_d;
         ncode_q      <= ncode_d;
         out1_q       <= out1_d;
         out2_q       <= out2_d;
         nrgwriaddr_q <= nrgwriaddr_d;
         nrgwritime_q <= nrgwritime_d;
      end
   end

   assign bus.npc        = npc_q;
   assign bus.ncode      = ncode_q;
   assign bus.out1       = out1_q;
   assign bus.out2       = out2_q;
   assign bus.nrgwriaddr = nrgwriaddr_q;
   assign bus.nrgwritime = nrgwritime_q;

   liushui_dm #(.DEPTH(DEPTH)) u_dm (
      .clk   (clk),
      .rst_n (reset),
      .we    (dm_we),
      .addr  (idx),
      .be    (dm_be),
      .wdata (dm_wdata),
      .rdata (dm_rdata)
   );

endmodule

// File: tb/tb_liushui_m.sv
// Directed bench for liushui_m: reset, store/load, W forwarding, address wrap,
// counter saturation, jal and (with LIUSHUI_M_SUBWORD_EN) sub-word access.
module tb_liushui_m;
   import liushui_m_pkg::*;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   liushui_m_if bus ();

   liushui_m #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] pc,
                        input logic [31:0] in1, input logic [31:0] in2,
                        input logic [4:0] dst, input logic [31:0] tm);
      bus.pc        = pc;
      bus.code      = {op, 5'd0, rt, 16'h0000};
      bus.in1       = in1;
      bus.in2       = in2;
      bus.rgwriaddr = dst;
      bus.rgwritime = tm;
   endtask

   task automatic wfwd(input logic [4:0] a, input logic [31:0] t, input logic [31:0] d);
      bus.W_rgwriaddr = a;
      bus.W_rgwritime = t;
      bus.W_rgwridata = d;
   endtask

   initial begin
      reset = 1'b1;
      wfwd(5'd0, 32'd1, 32'd0);
      drive(OP_LW, 5'd3, 32'h1234, 32'h40, 32'h99, 5'd9, 32'd7);
      #1 reset = 1'b0;
      #22;
      chk("rst_npc", bus.npc, 32'h3000);
      chk("rst_ncode", bus.ncode, 32'h0);
      chk("rst_out1", bus.out1, 32'h0);
      chk("rst_out2", bus.out2, 32'h0);
      chk("rst_waddr", {27'd0, bus.nrgwriaddr}, 32'h0);
      chk("rst_wtime", bus.nrgwritime, 32'h0);
      tick();
      reset = 1'b1;

      // sw then lw to the same word on consecutive cycles
      drive(OP_SW, 5'd1, 32'h3000, 32'h10, 32'hDEAD_BEEF, 5'd0, 32'd0);
      tick();
      chk("sw_out2", bus.out2, 32'h0);
      chk("sw_npc", bus.npc, 32'h3000);
      drive(OP_LW, 5'd2, 32'h3004, 32'h10, 32'h0, 5'd2, 32'd3);
      tick();
      chk("lw_out2", bus.out2, 32'hDEAD_BEEF);
      chk("lw_out1", bus.out1, 32'h10);
      chk("lw_waddr", {27'd0, bus.nrgwriaddr}, 32'd2);
      chk("lw_wtime", bus.nrgwritime, 32'd2);
      chk("lw_ncode", bus.ncode, {OP_LW, 5'd0, 5'd2, 16'h0});

      // store-data forwarding from W
      wfwd(5'd5, 32'd0, 32'h55);
      drive(OP_SW, 5'd5, 32'h3008, 32'h10, 32'h1, 5'd0, 32'd0);
      tick();
      wfwd(5'd0, 32'd1, 32'd0);
      drive(OP_LW, 5'd2, 32'h300C, 32'h10, 32'h0, 5'd2, 32'd0);
      tick();
      chk("fwd_hit", bus.out2, 32'h55);
      wfwd(5'd0, 32'd0, 32'h55);
      drive(OP_SW, 5'd0, 32'h3010, 32'h10, 32'h1, 5'd0, 32'd0);
      tick();
      wfwd(5'd0, 32'd1, 32'd0);
      drive(OP_LW, 5'd2, 32'h3014, 32'h10, 32'h0, 5'd2, 32'd0);
      tick();
      chk("fwd_rt0", bus.out2, 32'h1);
      wfwd(5'd5, 32'd1, 32'h55);
      drive(OP_SW, 5'd5, 32'h3018, 32'h10, 32'h77, 5'd0, 32'd0);
      tick();
      drive(OP_LW, 5'd2, 32'h301C, 32'h10, 32'h0, 5'd2, 32'd0);
      tick();
      chk("fwd_notready", bus.out2, 32'h77);
      wfwd(5'd6, 32'd0, 32'h55);
      drive(OP_SW, 5'd5, 32'h3020, 32'h10, 32'h88, 5'd0, 32'd0);
      tick();
      wfwd(5'd0, 32'd1, 32'd0);
      drive(OP_LW, 5'd2, 32'h3024, 32'h10, 32'h0, 5'd2, 32'd0);
      tick();
      chk("fwd_addrmiss", bus.out2, 32'h88);

      // address wrap and unaligned load
      drive(OP_SW, 5'd1, 32'h3028, DEPTH * 4 + 8, 32'hA5A5_A5A5, 5'd0, 32'd0);
      tick();
      drive(OP_LW, 5'd2, 32'h302C, 32'h8, 32'h0, 5'd2, 32'd0);
      tick();
      chk("wrap_lw", bus.out2, 32'hA5A5_A5A5);
      drive(OP_LW, 5'd2, 32'h3030, 32'hB, 32'h0, 5'd2, 32'd0);
      tick();
      chk("unalign_lw", bus.out2, 32'hA5A5_A5A5);

      // availability counter
      drive(6'h00, 5'd0, 32'h3034, 32'h1234, 32'h0, 5'd7, 32'd2);
      tick();
      chk("cnt_2", bus.nrgwritime, 32'd1);
      chk("alu_out1", bus.out1, 32'h1234);
      chk("alu_out2", bus.out2, 32'h0);
      drive(6'h00, 5'd0, 32'h3038, 32'h1234, 32'h0, 5'd7, 32'd0);
      tick();
      chk("cnt_0", bus.nrgwritime, 32'd0);

      // jal and combinational M result
      drive(OP_JAL, 5'd0, 32'h3010, 32'hABC, 32'h0, 5'd31, 32'd0);
      #1 chk("jal_comb", bus.M_rgwridata, 32'h3018);
      tick();
      chk("jal_out1", bus.out1, 32'h3018);
      drive(6'h00, 5'd0, 32'h3040, 32'h4321, 32'h0, 5'd1, 32'd0);
      #1 chk("alu_comb", bus.M_rgwridata, 32'h4321);

      // mid-run reset clears latch and memory immediately
      #2 reset = 1'b0;
      #1;
      chk("mrst_npc", bus.npc, 32'h3000);
      chk("mrst_out1", bus.out1, 32'h0);
      drive(OP_LW, 5'd2, 32'h3044, 32'h8, 32'h0, 5'd2, 32'd0);
      #1 reset = 1'b1;
      tick();
      chk("mrst_lw", bus.out2, 32'h0);
      chk("mrst_npc2", bus.npc, 32'h3044);

      drive(OP_SW, 5'd1, 32'h3048, 32'h0, 32'h1122_3344, 5'd0, 32'd0);
      tick();
      drive(OP_SB, 5'd1, 32'h304C, 32'h1, 32'hFF, 5'd0, 32'd0);
      tick();
      drive(OP_LW, 5'd2, 32'h3050, 32'h0, 32'h0, 5'd2, 32'd0);
      tick();
`ifdef LIUSHUI_M_SUBWORD_EN
      chk("sb_word", bus.out2, 32'h1122_FF44);
      drive(OP_LB, 5'd2, 32'h3054, 32'h1, 32'h0, 5'd2, 32'd0);
      tick();
      chk("lb", bus.out2, 32'hFFFF_FFFF);
      drive(OP_LBU, 5'd2, 32'h3058, 32'h1, 32'h0, 5'd2, 32'd0);
      tick();
      chk("lbu", bus.out2, 32'h0000_00FF);
      drive(OP_SH, 5'd1, 32'h305C, 32'h3, 32'h8000, 5'd0, 32'd0);
      tick();
      drive(OP_LW, 5'd2, 32'h3060, 32'h0, 32'h0, 5'd2, 32'd0);
      tick();
      chk("sh_word", bus.out2, 32'h8000_FF44);
      drive(OP_LH, 5'd2, 32'h3064, 32'h2, 32'h0, 5'd2, 32'd0);
      tick();
      chk("lh_hi", bus.out2, 32'hFFFF_8000);
      drive(OP_LHU, 5'd2, 32'h3068, 32'h3, 32'h0, 5'd2, 32'd0);
      tick();
      chk("lhu_hi", bus.out2, 32'h0000_8000);
      drive(OP_LH, 5'd2, 32'h306C, 32'h0, 32'h0, 5'd2, 32'd0);
      tick();
      chk("lh_lo", bus.out2, 32'hFFFF_FF44);
`else
      chk("sb_nowrite", bus.out2, 32'h1122_3344);
      drive(OP_LB, 5'd2, 32'h3054, 32'h1, 32'h0, 5'd2, 32'd0);
      tick();
      chk("lb_other", bus.out2, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
